// File: rtl/pfb_reload_pkg.sv
// ============================================================================
// Module   : pfb_reload_pkg
// Brief    : Shared constants and state encoding for the PFB coefficient reload path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pfb_reload_pkg;

  localparam int RELOAD_TDATA_WIDTH = 32;
  localparam int PFB_NUM_COEFFS     = 16384;
  localparam int PFB_COEF_WIDTH     = 25;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } reload_state_e;

endpackage

`default_nettype wire

// File: rtl/pfb_reload_fifo.sv
// ============================================================================
// Module   : pfb_reload_fifo
// Brief    : Synchronous skid FIFO holding {last, coefficient} between RAM and stream.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pfb_reload_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  assign empty    = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_wr     = push && (!w_full || pop);
  assign w_rd     = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pfb_coef_reload_streamer.sv
// ============================================================================
// Module   : pfb_coef_reload_streamer
// Brief    : Streams NUM_COEFFS staging-RAM words to the PFB reload port over AXI-S.
//            Optional frame checksum enabled by defining PFB_RELOAD_CKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pfb_coef_reload_streamer
  import pfb_reload_pkg::*;
#(
  parameter int NUM_COEFFS = PFB_NUM_COEFFS,
  parameter int ADDR_WIDTH = 14,
  parameter int COEF_WIDTH = PFB_COEF_WIDTH,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          sync_reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          coef_rd_en,
  output logic [ADDR_WIDTH-1:0]         coef_addr,
  input  logic [COEF_WIDTH-1:0]         coef_rdata,
  output logic                          m_axis_reload_tvalid,
  output logic [RELOAD_TDATA_WIDTH-1:0] m_axis_reload_tdata,
  output logic                          m_axis_reload_tlast,
  input  logic                          m_axis_reload_tready,
  output logic [RELOAD_TDATA_WIDTH-1:0] frame_cksum
);

  localparam int                    CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0]      c_depth     = CNT_W'(FIFO_DEPTH);

  reload_state_e          r_state;
  reload_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]       r_used;
  logic [RD_LATENCY-1:0]  r_tag_vld;
  logic [RD_LATENCY-1:0]  r_tag_last;
  logic                   r_done;
  logic                   w_rd_en;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_start_acc;
  logic                   w_last_beat;
  logic [COEF_WIDTH:0]    w_head;

  assign w_pop       = !w_empty && m_axis_reload_tready;
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_last_beat = w_pop && w_head[COEF_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        // r_used covers FIFO entries plus reads still in the RAM pipe.
        w_rd_en = (r_used < c_depth) || w_pop;
        if (w_rd_en && (r_rd_cnt == c_last_addr)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state    <= S_IDLE;
      r_rd_cnt   <= '0;
      r_used     <= '0;
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_DRAIN) && w_last_beat;
      if (w_start_acc)  r_rd_cnt <= '0;
      else if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
      case ({w_rd_en, w_pop})
        2'b10:   r_used <= r_used + 1'b1;
        2'b01:   r_used <= r_used - 1'b1;
        default: r_used <= r_used;
      endcase
      r_tag_vld[0]  <= w_rd_en;
      r_tag_last[0] <= w_rd_en && (r_rd_cnt == c_last_addr);
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_last[i] <= r_tag_last[i-1];
      end
    end
  end

  pfb_reload_fifo #(
    .WIDTH (COEF_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .sync_reset(sync_reset),
    .push      (r_tag_vld[RD_LATENCY-1]),
    .push_data ({r_tag_last[RD_LATENCY-1], coef_rdata}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_empty)
  );

  assign busy                 = (r_state != S_IDLE);
  assign done                 = r_done;
  assign coef_rd_en           = w_rd_en;
  assign coef_addr            = r_rd_cnt;
  assign m_axis_reload_tvalid = !w_empty;
  assign m_axis_reload_tlast  = !w_empty && w_head[COEF_WIDTH];
  assign m_axis_reload_tdata  = {{(RELOAD_TDATA_WIDTH-COEF_WIDTH){w_head[COEF_WIDTH-1]}},
                                 w_head[COEF_WIDTH-1:0]};

`ifdef PFB_RELOAD_CKSUM_EN
  logic [RELOAD_TDATA_WIDTH-1:0] r_cksum;

  always_ff @(posedge clk) begin
    if (sync_reset)       r_cksum <= '0;
    else if (w_start_acc) r_cksum <= '0;
    else if (w_pop)       r_cksum <= r_cksum + m_axis_reload_tdata;
  end

  assign frame_cksum = r_cksum;
`else
  assign frame_cksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pfb_coef_reload_streamer.sv
// ============================================================================
// Module   : tb_pfb_coef_reload_streamer
// Brief    : Scoreboard bench for the coefficient reload streamer (random backpressure).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pfb_coef_reload_streamer;

  localparam int N  = 16384;
  localparam int AW = 14;
  localparam int CW = 25;
  localparam int L  = 3;
  localparam int FD = 8;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          coef_rd_en;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_rdata;
  logic          tvalid;
  logic [31:0]   tdata;
  logic          tlast;
  logic          tready;
  logic [31:0]   frame_cksum;

  beat_t         exp_q[$];
  logic [31:0]   ck_q[$];
  logic [CW-1:0] ram_salt;
  logic [CW-1:0] ram_pipe [L];
  int            n_pass  = 0;
  int            n_total = 0;
  int            done_cnt = 0;
  int            beat_idx = 0;
  int            mode = 0;
  logic          prev_stall = 1'b0;
  logic          prev_last_hs = 1'b0;
  logic [31:0]   prev_data;
  logic          prev_last;

  always #5 clk = ~clk;

  pfb_coef_reload_streamer #(
    .NUM_COEFFS(N), .ADDR_WIDTH(AW), .COEF_WIDTH(CW), .RD_LATENCY(L), .FIFO_DEPTH(FD)
  ) dut (
    .clk                 (clk),
    .sync_reset          (sync_reset),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .coef_rd_en          (coef_rd_en),
    .coef_addr           (coef_addr),
    .coef_rdata          (coef_rdata),
    .m_axis_reload_tvalid(tvalid),
    .m_axis_reload_tdata (tdata),
    .m_axis_reload_tlast (tlast),
    .m_axis_reload_tready(tready),
    .frame_cksum         (frame_cksum)
  );

  // Staging RAM contents: address XOR a per-frame salt, with a negative word at address 5.
  function automatic logic [CW-1:0] ram_word(input logic [AW-1:0] a, input logic [CW-1:0] s);
    if (a == AW'(5)) return 25'h1000000;
    return CW'(a) ^ s;
  endfunction

  always @(posedge clk) begin
    ram_pipe[0] <= coef_rd_en ? ram_word(coef_addr, ram_salt) : CW'($urandom);
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign coef_rdata = ram_pipe[L-1];

  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       tready = 1'b1;
        1:       tready = 1'($urandom_range(0, 1));
        default: tready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: actual %h required %h", name, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    beat_t e;
    logic [31:0] ck;
    if (sync_reset) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
      beat_idx     = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(tvalid), 32'd1);
        chk("stall_tdata", tdata, prev_data);
        chk("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      if (done || prev_last_hs) begin
        chk("done_pulse", 32'(done), 32'(prev_last_hs));
        chk("busy_at_done", 32'(busy), 32'd0);
        if (done) begin
          done_cnt++;
          ck = (ck_q.size() != 0) ? ck_q.pop_front() : 32'hDEADBEEF;
          chk("frame_cksum", frame_cksum, ck);
        end
      end
      prev_last_hs = 1'b0;
      if (tvalid && tready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tdata", tdata, e.d);
          chk("tlast", 32'(tlast), 32'(e.l));
        end
        prev_last_hs = tlast;
        beat_idx = tlast ? 0 : beat_idx + 1;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // Called just after a rising edge; pushes the whole expected frame on accepted start.
  task automatic issue_start(input logic [CW-1:0] s);
    beat_t b;
    logic [CW-1:0] w;
    logic [31:0] sum;
    sum = 32'd0;
    ram_salt = s;
    start = 1'b1;
    for (int i = 0; i < N; i++) begin
      w   = ram_word(AW'(i), s);
      b.d = {{(32-CW){w[CW-1]}}, w};
      b.l = (i == N - 1);
      exp_q.push_back(b);
      sum = sum + b.d;
    end
`ifdef PFB_RELOAD_CKSUM_EN
    ck_q.push_back(sum);
`else
    ck_q.push_back(32'd0);
`endif
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("done_within_budget", 32'(done_cnt != base), 32'd1);
    #1;
  endtask

  task automatic mid_reset();
    sync_reset = 1'b1;
    exp_q.delete();
    ck_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(coef_rd_en), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_addr", 32'(coef_addr), 32'd0);
    chk("rst_cksum", frame_cksum, 32'd0);
    sync_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int cnt;
    int n;
    sync_reset = 1'b1;
    start      = 1'b0;
    ram_salt   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_tvalid", 32'(tvalid), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_done", 32'(done), 32'd0);
    chk("init_rd_en", 32'(coef_rd_en), 32'd0);
    chk("init_addr", 32'(coef_addr), 32'd0);
    chk("init_cksum", frame_cksum, 32'd0);
    @(posedge clk);
    #1 sync_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame A: data = address, full throughput, stray start while busy.
    mode = 0;
    issue_start('0);
    lat = 1;
    while (lat < 50) begin
      @(negedge clk);
      if (tvalid) break;
      @(posedge clk);
      lat++;
    end
    chk("first_beat_latency", 32'(lat), 32'(L + 2));
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(N + 100);
    chk("frame_a_all_beats", 32'(exp_q.size()), 32'd0);

    // Frame B: random salt, 50% backpressure.
    mode = 1;
    issue_start(CW'($urandom));
    wait_done(4 * N);
    chk("frame_b_all_beats", 32'(exp_q.size()), 32'd0);

    // Stall: no ready -> exactly FIFO_DEPTH reads outstanding; then abort at beat 1000.
    mode = 2;
    issue_start(CW'($urandom));
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (coef_rd_en) cnt++;
    end
    chk("stall_reads", 32'(cnt), 32'(FD));
    chk("stall_tvalid_held", 32'(tvalid), 32'd1);
    mode = 0;
    n = 0;
    while (beat_idx < 1000 && n < 3000) begin
      @(posedge clk);
      #1 n++;
    end
    chk("reached_beat_1000", 32'(beat_idx), 32'd1000);
    mid_reset();

    // Frame C after abort, then frame D started in the done cycle.
    issue_start(CW'($urandom));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < N + 100);
    chk("frame_c_done_seen", 32'(done), 32'd1);
    issue_start(CW'($urandom));
    repeat (60) @(posedge clk);
    #1;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_streaming", 32'(beat_idx > 40), 32'd1);
    mid_reset();

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("end_idle_tvalid", 32'(tvalid), 32'd0);
    chk("end_idle_busy", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
